// File: rtl/min_sec_counter_pkg.sv
// -----------------------------------------------------------------------------
// min_sec_counter_pkg
// Shared constants and types for the minutes/seconds timebase.
//   ONES_MAX / SEC_TENS_MAX / MIN_TENS_MAX : terminal value of each BCD digit
//   ONES_W / TENS_W                        : digit widths
//   DEFAULT_CLK_DIV                        : clk_in cycles per second
//   presc_width()                          : prescaler register width for a divider
// -----------------------------------------------------------------------------
package min_sec_counter_pkg;

    localparam int ONES_W          = 4;
    localparam int TENS_W          = 3;
    localparam int ONES_MAX        = 9;
    localparam int SEC_TENS_MAX    = 5;
    localparam int MIN_TENS_MAX    = 5;
    localparam int DEFAULT_CLK_DIV = 1000000;

    // Display digits bundled in reading order mm:ss.
    typedef struct packed {
        logic [TENS_W-1:0] min_tens;
        logic [ONES_W-1:0] min_ones;
        logic [TENS_W-1:0] sec_tens;
        logic [ONES_W-1:0] sec_ones;
    } time_bcd_t;

    // Bits needed to hold 0..div-1; never less than one bit.
    function automatic int presc_width(input int div);
        int w;
        if (div <= 2) begin
            w = 1;
        end else begin
            w = $clog2(div);
        end
        return w;
    endfunction

endpackage

// File: rtl/min_sec_counter_if.sv
// -----------------------------------------------------------------------------
// min_sec_counter_if
// Control and display bundle of the minutes/seconds timebase.
//   run                 : count enable (into the counter)
//   set_min             : minute-set pulse, only when TIME_SET_EN is defined
//   sec_ones..min_tens  : BCD display digits (out of the counter)
//   sec_tick, hour_tick : one-cycle pulses (out of the counter)
// Modports: master = the counter, slave = the controller/consumer side.
// -----------------------------------------------------------------------------
interface min_sec_counter_if;
    import min_sec_counter_pkg::*;

    logic              run;
`ifdef TIME_SET_EN
    logic              set_min;
`endif
    logic [ONES_W-1:0] sec_ones;
    logic [TENS_W-1:0] sec_tens;
    logic [ONES_W-1:0] min_ones;
    logic [TENS_W-1:0] min_tens;
    logic              sec_tick;
    logic              hour_tick;

    modport master (
        input  run,
`ifdef TIME_SET_EN
        input  set_min,
`endif
        output sec_ones,
        output sec_tens,
        output min_ones,
        output min_tens,
        output sec_tick,
        output hour_tick
    );

    modport slave (
        output run,
`ifdef TIME_SET_EN
        output set_min,
`endif
        input  sec_ones,
        input  sec_tens,
        input  min_ones,
        input  min_tens,
        input  sec_tick,
        input  hour_tick
    );

endinterface

// File: rtl/min_sec_counter_bcd_digit_cnt.sv
// -----------------------------------------------------------------------------
// bcd_digit_cnt
// One registered digit of a modulo-(MAX+1) carry chain.
//   clk_in : clock          rst   : async active-high reset
//   inc    : step by one    clr   : synchronous clear, wins over inc
//   value  : registered digit
//   carry  : inc while value==MAX (next digit steps on the same edge)
// Any value above MAX returns to 0 on the next increment.
// -----------------------------------------------------------------------------
module bcd_digit_cnt #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

    logic [WIDTH-1:0] value_r;

    // Digit register: clear, wrap at MAX (or from an illegal value), else step.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            value_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            value_r <= {WIDTH{1'b0}};
        end else if (inc) begin
            if (value_r >= LAST) begin
                value_r <= {WIDTH{1'b0}};
            end else begin
                value_r <= value_r + WIDTH'(1);
            end
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
    assign carry = inc && (value_r == LAST);

endmodule

// File: rtl/min_sec_counter.sv
// -----------------------------------------------------------------------------
// min_sec_counter
// Divides clk_in by CLK_DIV to a 1 Hz step and counts mm:ss 00:00..59:59 in
// BCD, emitting sec_tick on each step and hour_tick on the 59:59->00:00 wrap.
//   clk_in : system clock (rising edge)
//   rst    : asynchronous active-high reset
//   bus    : min_sec_counter_if.master (run, [set_min], digits, ticks)
// Optional feature macro: TIME_SET_EN adds set_min (minute advance, clears
// seconds and prescaler, never raises a tick, takes priority over a wrap).
// -----------------------------------------------------------------------------
module min_sec_counter
    import min_sec_counter_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                  clk_in,
    input  logic                  rst,
    min_sec_counter_if.master     bus
);

    localparam int                 PRESC_W    = presc_width(CLK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_r;
    logic               wrap_s;
    logic               set_s;
    logic               sec_ones_carry_s;
    logic               sec_tens_carry_s;
    logic               min_ones_inc_s;
    logic               min_ones_carry_s;
    logic               min_tens_carry_s;
    logic               sec_tick_r;
    logic               hour_tick_r;
    time_bcd_t          disp_s;

`ifdef TIME_SET_EN
    assign set_s = bus.set_min;
`else
    assign set_s = 1'b0;
`endif

    assign wrap_s = bus.run && (presc_r == PRESC_LAST);

    // A set pulse steps minutes directly; otherwise minutes follow the seconds carry.
    assign min_ones_inc_s = set_s | sec_tens_carry_s;

    // Prescaler: holds while run is low so counting resumes at the same phase.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (set_s || wrap_s) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (bus.run) begin
            presc_r <= presc_r + PRESC_W'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Tick pulses, registered alongside the digit update; a set suppresses both.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sec_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
        end else begin
            sec_tick_r  <= wrap_s && !set_s;
            hour_tick_r <= wrap_s && !set_s && min_tens_carry_s;
        end
    end

    bcd_digit_cnt #(.WIDTH(ONES_W), .MAX(ONES_MAX)) u_sec_ones (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (wrap_s),
        .clr    (set_s),
        .value  (disp_s.sec_ones),
        .carry  (sec_ones_carry_s)
    );

    bcd_digit_cnt #(.WIDTH(TENS_W), .MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (sec_ones_carry_s),
        .clr    (set_s),
        .value  (disp_s.sec_tens),
        .carry  (sec_tens_carry_s)
    );

    bcd_digit_cnt #(.WIDTH(ONES_W), .MAX(ONES_MAX)) u_min_ones (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (min_ones_inc_s),
        .clr    (1'b0),
        .value  (disp_s.min_ones),
        .carry  (min_ones_carry_s)
    );

    bcd_digit_cnt #(.WIDTH(TENS_W), .MAX(MIN_TENS_MAX)) u_min_tens (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (min_ones_carry_s),
        .clr    (1'b0),
        .value  (disp_s.min_tens),
        .carry  (min_tens_carry_s)
    );

    assign bus.sec_ones  = disp_s.sec_ones;
    assign bus.sec_tens  = disp_s.sec_tens;
    assign bus.min_ones  = disp_s.min_ones;
    assign bus.min_tens  = disp_s.min_tens;
    assign bus.sec_tick  = sec_tick_r;
    assign bus.hour_tick = hour_tick_r;

endmodule
